// File: rtl/dfi_resp_pkg.sv
// dfi_resp_pkg: shared types, error-bit indices and command decoder for the
// DFI PHY responder.
package dfi_resp_pkg;

  typedef enum logic [2:0] {
    NOP,
    ACT,
    PRE,
    RD,
    WR,
    REF
  } dfi_cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } init_state_e;

  // Sticky error flag positions in err[3:0].
  localparam int unsigned ERR_REF_OPEN    = 0;  // REF while a bank is open
  localparam int unsigned ERR_PROTO       = 1;  // queue overflow / orphan data beat
  localparam int unsigned ERR_CLOSED_BANK = 2;  // RD/WR to closed bank (or tRCD)
  localparam int unsigned ERR_NOT_INIT    = 3;  // command before init complete

  // Commands only decode when selected and clocked; ras/cas/we encoding.
  function automatic dfi_cmd_e decode_cmd(input logic cs_n, input logic cke,
                                          input logic ras_n, input logic cas_n,
                                          input logic we_n);
    dfi_cmd_e c;
    c = NOP;
    if (!cs_n && cke) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  c = ACT;
        3'b010:  c = PRE;
        3'b101:  c = RD;
        3'b100:  c = WR;
        3'b001:  c = REF;
        default: c = NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/dfi_resp_addr_q.sv
// dfi_resp_addr_q: small FIFO of burst base indices. The head entry is
// consumed one beat at a time and pops after BEATS beats. Push and pop in the
// same cycle are both accepted, even when full.
module dfi_resp_addr_q
  import dfi_resp_pkg::*;
#(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BEATS = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [AW-1:0] push_idx,
  input  logic          beat,
  output logic [AW-1:0] beat_idx,
  output logic          beat_ok,
  output logic          beat_drop,
  output logic          push_drop
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [AW-1:0] entries [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [BW-1:0] beat_cnt;
  logic          empty;
  logic          full;
  logic          last_beat;
  logic          pop;
  logic          push_ok;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign beat_ok   = beat && !empty;
  assign beat_drop = beat && empty;
  assign pop       = beat_ok && last_beat;
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && full && !pop;
  assign beat_idx  = entries[rd_ptr] + AW'(beat_cnt);

  // Pointer, occupancy and beat-counter control.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (beat_ok) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // Entry storage; contents are don't-care while not occupied.
  always_ff @(posedge clk) begin
    if (push_ok) entries[wr_ptr] <= push_idx;
  end

endmodule

// File: rtl/dfi_phy_responder.sv
// dfi_phy_responder: behavioural DFI slave standing in for PHY + DRAM.
// Decodes commands, tracks open banks, stores write data and returns read
// data after a fixed latency. Define DFI_RESP_TIMING_CHECK_EN to add a
// per-bank tRCD check that flags RD/WR within 4 cycles of ACT.
module dfi_phy_responder
  import dfi_resp_pkg::*;
#(
  parameter int unsigned C_DFI_ADDR_WIDTH = 16,
  parameter int unsigned C_DFI_BANK_WIDTH = 3,
  parameter int unsigned C_DFI_DATA_WIDTH = 128,
  parameter int unsigned C_MEM_AW         = 8,
  parameter int unsigned C_TPHY_RDLAT     = 4,
  parameter int unsigned C_BURST_BEATS    = 4,
  parameter int unsigned C_INIT_CYCLES    = 16,
  parameter int unsigned C_CMDQ_DEPTH     = 4
) (
  input  logic                          core_clk,
  input  logic                          core_arstn,
  input  logic [C_DFI_ADDR_WIDTH-1:0]   dfi_address,
  input  logic [C_DFI_BANK_WIDTH-1:0]   dfi_bank,
  input  logic                          dfi_cs_n,
  input  logic                          dfi_ras_n,
  input  logic                          dfi_cas_n,
  input  logic                          dfi_we_n,
  input  logic                          dfi_cke,
  input  logic                          dfi_wrdata_en,
  input  logic [C_DFI_DATA_WIDTH-1:0]   dfi_wrdata,
  input  logic [C_DFI_DATA_WIDTH/8-1:0] dfi_wrdata_mask,
  input  logic                          dfi_rddata_en,
  output logic [C_DFI_DATA_WIDTH-1:0]   dfi_rddata,
  output logic                          dfi_rddata_valid,
  input  logic                          dfi_init_start,
  output logic                          dfi_init_complete,
  output logic [3:0]                    err
);

  localparam int unsigned NUM_BANKS = 2 ** C_DFI_BANK_WIDTH;
  localparam int unsigned NUM_BYTES = C_DFI_DATA_WIDTH / 8;
  localparam int unsigned MEM_WORDS = 2 ** C_MEM_AW;
  // Storage index is {bank, row low bits, column low bits}; the bits left
  // after the bank are split between column (rounded up) and row.
  localparam int unsigned IDX_COL_W = (C_MEM_AW - C_DFI_BANK_WIDTH + 1) / 2;
  localparam int unsigned IDX_ROW_W = C_MEM_AW - C_DFI_BANK_WIDTH - IDX_COL_W;
  localparam int unsigned INIT_W    = $clog2(C_INIT_CYCLES + 1);

  // ---------------------------------------------------------------- init FSM
  init_state_e       state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done;

  // Init state and cycle counter registers.
  always_ff @(posedge core_clk) begin
    if (!core_arstn) begin
      state_q    <= IDLE;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Counter holds cycles elapsed since the start cycle, so completion is
  // visible exactly C_INIT_CYCLES cycles after dfi_init_start.
  always_comb begin
    state_d           = state_q;
    init_cnt_d        = init_cnt_q;
    dfi_init_complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dfi_init_start) begin
          init_cnt_d = INIT_W'(1);
          state_d    = (C_INIT_CYCLES <= 1) ? DONE : COUNT;
        end
      end
      COUNT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_W'(C_INIT_CYCLES - 1)) state_d = DONE;
      end
      DONE: dfi_init_complete = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign init_done = (state_q == DONE);

  // ---------------------------------------------------------- command decode
  dfi_cmd_e cmd;
  logic     cmd_valid;
  logic     cmd_ok;

  assign cmd       = decode_cmd(dfi_cs_n, dfi_cke, dfi_ras_n, dfi_cas_n, dfi_we_n);
  assign cmd_valid = (cmd != NOP);
  assign cmd_ok    = cmd_valid && init_done;

  // Only the address bits that feed the index and PRE-all are consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dfi_address;

  // -------------------------------------------------------------- bank state
  logic [NUM_BANKS-1:0] bank_open;
  logic [IDX_ROW_W-1:0] bank_row [NUM_BANKS];
  logic [C_MEM_AW-1:0]  cmd_idx;
  logic                 bank_closed;
  logic                 trcd_viol;

  // Open/close banks and latch the row on ACT.
  always_ff @(posedge core_clk) begin
    if (!core_arstn) begin
      bank_open <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) bank_row[b] <= '0;
    end else if (cmd_ok) begin
      case (cmd)
        ACT: begin
          bank_open[dfi_bank] <= 1'b1;
          bank_row[dfi_bank]  <= dfi_address[IDX_ROW_W-1:0];
        end
        PRE: begin
          if (dfi_address[10]) bank_open <= '0;
          else                 bank_open[dfi_bank] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cmd_idx     = {dfi_bank, bank_row[dfi_bank], dfi_address[IDX_COL_W-1:0]};
  assign bank_closed = !bank_open[dfi_bank];

`ifdef DFI_RESP_TIMING_CHECK_EN
  logic [1:0] trcd_cnt [NUM_BANKS];

  // Per-bank cycles-since-ACT, saturating at 3 (= tRCD satisfied).
  always_ff @(posedge core_clk) begin
    if (!core_arstn) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) trcd_cnt[b] <= '1;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (cmd_ok && cmd == ACT && dfi_bank == C_DFI_BANK_WIDTH'(b))
          trcd_cnt[b] <= '0;
        else if (trcd_cnt[b] != 2'd3)
          trcd_cnt[b] <= trcd_cnt[b] + 2'd1;
      end
    end
  end

  assign trcd_viol = (trcd_cnt[dfi_bank] != 2'd3);
`else
  assign trcd_viol = 1'b0;
`endif

  // ------------------------------------------------------------ addr queues
  logic                rq_push, wq_push;
  logic [C_MEM_AW-1:0] rq_idx, wq_idx;
  logic                rq_ok, wq_ok;
  logic                rq_beat_drop, wq_beat_drop;
  logic                rq_push_drop, wq_push_drop;

  assign rq_push = cmd_ok && (cmd == RD);
  assign wq_push = cmd_ok && (cmd == WR);

  dfi_resp_addr_q #(
    .AW    (C_MEM_AW),
    .DEPTH (C_CMDQ_DEPTH),
    .BEATS (C_BURST_BEATS)
  ) u_rd_q (
    .clk       (core_clk),
    .rstn      (core_arstn),
    .push      (rq_push),
    .push_idx  (cmd_idx),
    .beat      (dfi_rddata_en),
    .beat_idx  (rq_idx),
    .beat_ok   (rq_ok),
    .beat_drop (rq_beat_drop),
    .push_drop (rq_push_drop)
  );

  dfi_resp_addr_q #(
    .AW    (C_MEM_AW),
    .DEPTH (C_CMDQ_DEPTH),
    .BEATS (C_BURST_BEATS)
  ) u_wr_q (
    .clk       (core_clk),
    .rstn      (core_arstn),
    .push      (wq_push),
    .push_idx  (cmd_idx),
    .beat      (dfi_wrdata_en),
    .beat_idx  (wq_idx),
    .beat_ok   (wq_ok),
    .beat_drop (wq_beat_drop),
    .push_drop (wq_push_drop)
  );

  // ----------------------------------------------------------------- storage
  logic [C_DFI_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [C_DFI_DATA_WIDTH-1:0] rd_word;

  // Byte-masked write; not reset. The read below samples the pre-write word,
  // giving read-before-write on same-index collisions.
  always_ff @(posedge core_clk) begin
    if (wq_ok) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (!dfi_wrdata_mask[i]) mem[wq_idx][i*8 +: 8] <= dfi_wrdata[i*8 +: 8];
      end
    end
  end

  assign rd_word = rq_ok ? mem[rq_idx] : '0;

  // --------------------------------------------------------- read delay line
  logic                        pipe_valid [C_TPHY_RDLAT];
  logic [C_DFI_DATA_WIDTH-1:0] pipe_data  [C_TPHY_RDLAT];

  // Every rddata_en beat produces one valid, orphan beats carry zero data.
  always_ff @(posedge core_clk) begin
    if (!core_arstn) begin
      for (int unsigned i = 0; i < C_TPHY_RDLAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_data[i]  <= '0;
      end
    end else begin
      pipe_valid[0] <= dfi_rddata_en;
      pipe_data[0]  <= rd_word;
      for (int unsigned i = 1; i < C_TPHY_RDLAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign dfi_rddata_valid = pipe_valid[C_TPHY_RDLAT-1];
  assign dfi_rddata       = pipe_data[C_TPHY_RDLAT-1];

  // ------------------------------------------------------------ error flags
  logic [3:0] err_set;

  // Collect this cycle's protocol violations.
  always_comb begin
    err_set                  = '0;
    err_set[ERR_NOT_INIT]    = cmd_valid && !init_done;
    err_set[ERR_REF_OPEN]    = cmd_ok && (cmd == REF) && (|bank_open);
    err_set[ERR_PROTO]       = rq_push_drop | wq_push_drop | rq_beat_drop | wq_beat_drop;
    err_set[ERR_CLOSED_BANK] = cmd_ok && ((cmd == RD) || (cmd == WR)) &&
                               (bank_closed || trcd_viol);
  end

  // Sticky error register.
  always_ff @(posedge core_clk) begin
    if (!core_arstn) err <= '0;
    else             err <= err | err_set;
  end

endmodule

// File: tb/tb_dfi_phy_responder.sv
// tb_dfi_phy_responder: directed self-checking bench for dfi_phy_responder.
module tb_dfi_phy_responder;

  localparam int LAT   = 4;
  localparam int BEATS = 4;
  localparam int INIT  = 16;

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_REF = 3'b001;

  logic         core_clk = 1'b0;
  logic         core_arstn = 1'b0;
  logic [15:0]  dfi_address = '0;
  logic [2:0]   dfi_bank = '0;
  logic         dfi_cs_n = 1'b1;
  logic         dfi_ras_n = 1'b1;
  logic         dfi_cas_n = 1'b1;
  logic         dfi_we_n = 1'b1;
  logic         dfi_cke = 1'b1;
  logic         dfi_wrdata_en = 1'b0;
  logic [127:0] dfi_wrdata = '0;
  logic [15:0]  dfi_wrdata_mask = '0;
  logic         dfi_rddata_en = 1'b0;
  logic [127:0] dfi_rddata;
  logic         dfi_rddata_valid;
  logic         dfi_init_start = 1'b0;
  logic         dfi_init_complete;
  logic [3:0]   err;

  dfi_phy_responder #(
    .C_DFI_ADDR_WIDTH (16),
    .C_DFI_BANK_WIDTH (3),
    .C_DFI_DATA_WIDTH (128),
    .C_MEM_AW         (8),
    .C_TPHY_RDLAT     (LAT),
    .C_BURST_BEATS    (BEATS),
    .C_INIT_CYCLES    (INIT),
    .C_CMDQ_DEPTH     (4)
  ) dut (
    .core_clk          (core_clk),
    .core_arstn        (core_arstn),
    .dfi_address       (dfi_address),
    .dfi_bank          (dfi_bank),
    .dfi_cs_n          (dfi_cs_n),
    .dfi_ras_n         (dfi_ras_n),
    .dfi_cas_n         (dfi_cas_n),
    .dfi_we_n          (dfi_we_n),
    .dfi_cke           (dfi_cke),
    .dfi_wrdata_en     (dfi_wrdata_en),
    .dfi_wrdata        (dfi_wrdata),
    .dfi_wrdata_mask   (dfi_wrdata_mask),
    .dfi_rddata_en     (dfi_rddata_en),
    .dfi_rddata        (dfi_rddata),
    .dfi_rddata_valid  (dfi_rddata_valid),
    .dfi_init_start    (dfi_init_start),
    .dfi_init_complete (dfi_init_complete),
    .err               (err)
  );

  always #5 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [127:0] data;
  } obs_t;
  obs_t obs_q[$];

  // Log every read-data valid with the cycle it appeared in.
  always @(negedge core_clk) begin
    if (dfi_rddata_valid === 1'b1) obs_q.push_back('{cyc, dfi_rddata});
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge core_clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] rcw, input logic [2:0] bank, input logic [15:0] addr);
    dfi_cs_n = 1'b0;
    {dfi_ras_n, dfi_cas_n, dfi_we_n} = rcw;
    dfi_bank = bank;
    dfi_address = addr;
    tick(1);
    dfi_cs_n = 1'b1;
    {dfi_ras_n, dfi_cas_n, dfi_we_n} = 3'b111;
  endtask

  task automatic act(input logic [2:0] bank, input logic [15:0] row);
    issue(C_ACT, bank, row);
    tick(4);
  endtask

  task automatic do_reset();
    core_arstn = 1'b0;
    dfi_wrdata_en = 1'b0;
    dfi_rddata_en = 1'b0;
    dfi_init_start = 1'b0;
    tick(2);
    core_arstn = 1'b1;
  endtask

  task automatic do_init();
    dfi_init_start = 1'b1;
    tick(1);
    dfi_init_start = 1'b0;
    tick(INIT);
  endtask

  task automatic wr_beats(input int n, input logic [127:0] base, input logic [127:0] inc,
                          input logic [15:0] mask);
    for (int i = 0; i < n; i++) begin
      dfi_wrdata_en = 1'b1;
      dfi_wrdata = base + 128'(i) * inc;
      dfi_wrdata_mask = mask;
      tick(1);
    end
    dfi_wrdata_en = 1'b0;
    dfi_wrdata_mask = '0;
  endtask

  // Issue RD, pull BEATS beats, then expect BEATS valids exactly LAT cycles
  // after their rddata_en cycles carrying base + i*inc.
  task automatic read_check(input string tag, input logic [2:0] bank, input logic [15:0] col,
                            input logic [127:0] base, input logic [127:0] inc);
    int s;
    issue(C_RD, bank, col);
    obs_q.delete();
    s = cyc;
    dfi_rddata_en = 1'b1;
    tick(BEATS);
    dfi_rddata_en = 1'b0;
    tick(LAT + 2);
    check($sformatf("%s_count", tag), 128'(obs_q.size()), 128'(BEATS));
    for (int i = 0; i < BEATS && i < obs_q.size(); i++) begin
      check($sformatf("%s_cyc%0d", tag, i), 128'(obs_q[i].cyc), 128'(s + LAT + i));
      check($sformatf("%s_data%0d", tag, i), obs_q[i].data, base + 128'(i) * inc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;

    // Reset values
    tick(3);
    check("rst_valid", 128'(dfi_rddata_valid), 128'(0));
    check("rst_data", dfi_rddata, '0);
    check("rst_init", 128'(dfi_init_complete), 128'(0));
    check("rst_err", 128'(err), 128'(0));

    // Init handshake: complete exactly INIT cycles after the start cycle
    core_arstn = 1'b1;
    tick(1);
    dfi_init_start = 1'b1;
    s = cyc;
    tick(1);
    dfi_init_start = 1'b0;
    tick(INIT - 2);
    check("init_early", 128'(dfi_init_complete), 128'(0));
    tick(1);
    check("init_done", 128'(dfi_init_complete), 128'(1));
    check("init_cycle", 128'(cyc), 128'(s + INIT));
    check("init_err", 128'(err), 128'(0));

    // Write/read round trip: bank 2 row 0x10 col 0x08
    act(3'd2, 16'h0010);
    issue(C_WR, 3'd2, 16'h0008);
    wr_beats(4, {4{32'hA0A0_A0A0}}, 128'd1, 16'h0000);
    tick(2);
    read_check("rt", 3'd2, 16'h0008, {4{32'hA0A0_A0A0}}, 128'd1);
    check("rt_err", 128'(err), 128'(0));

    // Byte masking: all-ones, then zeros with byte 0 masked
    act(3'd1, 16'h0000);
    issue(C_WR, 3'd1, 16'h0000);
    wr_beats(4, '1, '0, 16'h0000);
    issue(C_WR, 3'd1, 16'h0000);
    wr_beats(4, '0, '0, 16'h0001);
    tick(1);
    read_check("mask", 3'd1, 16'h0000, 128'hFF, '0);
    check("mask_err", 128'(err), 128'(0));

    // Command before init sets err[3] and is ignored (bank stays closed)
    do_reset();
    issue(C_ACT, 3'd0, 16'h0000);
    check("preinit_err", 128'(err), 128'(8));
    do_init();
    issue(C_RD, 3'd0, 16'h0000);
    tick(1);
    check("preinit_ignored", 128'(err), 128'(12));

    // Closed bank access, sticky err[2], REF / PRE-all behaviour
    do_reset();
    do_init();
    issue(C_RD, 3'd5, 16'h0000);
    tick(1);
    check("closed_err", 128'(err), 128'(4));
    tick(100);
    check("closed_sticky", 128'(err), 128'(4));
    issue(C_REF, 3'd0, 16'h0000);
    tick(1);
    check("ref_closed", 128'(err), 128'(4));
    act(3'd0, 16'h0000);
    act(3'd6, 16'h0000);
    issue(C_PRE, 3'd3, 16'h0400);
    issue(C_REF, 3'd0, 16'h0000);
    tick(1);
    check("ref_after_prea", 128'(err), 128'(4));
    act(3'd0, 16'h0000);
    issue(C_REF, 3'd0, 16'h0000);
    tick(1);
    check("ref_open", 128'(err), 128'(5));

    // Write queue overflow: 5 WR, depth 4, then 16 beats drain 4 entries
    do_reset();
    do_init();
    for (int b = 0; b < 5; b++) act(3'(b), 16'h0000);
    issue(C_WR, 3'd4, 16'h0000);
    wr_beats(4, {8{16'h5A5A}}, '0, 16'h0000);
    check("ovf_pre_err", 128'(err), 128'(0));
    for (int b = 0; b < 5; b++) issue(C_WR, 3'(b), 16'h0000);
    check("ovf_err", 128'(err), 128'(2));
    wr_beats(16, 128'h100, 128'd1, 16'h0000);
    wr_beats(1, 128'hDEAD, '0, 16'h0000);
    tick(1);
    read_check("ovf_b0", 3'd0, 16'h0000, 128'h100, 128'd1);
    read_check("ovf_b3", 3'd3, 16'h0000, 128'h10C, 128'd1);
    read_check("ovf_b4", 3'd4, 16'h0000, {8{16'h5A5A}}, '0);
    check("ovf_err_end", 128'(err), 128'(2));

    // Reset during read beat 2 aborts the burst and empties queues
    do_reset();
    do_init();
    act(3'd0, 16'h0000);
    issue(C_RD, 3'd0, 16'h0000);
    obs_q.delete();
    dfi_rddata_en = 1'b1;
    tick(2);
    core_arstn = 1'b0;
    tick(1);
    core_arstn = 1'b1;
    dfi_rddata_en = 1'b0;
    check("mid_valid", 128'(dfi_rddata_valid), 128'(0));
    check("mid_err", 128'(err), 128'(0));
    check("mid_init", 128'(dfi_init_complete), 128'(0));
    tick(LAT + 2);
    check("mid_no_valids", 128'(obs_q.size()), 128'(0));
    s = cyc;
    dfi_rddata_en = 1'b1;
    tick(1);
    dfi_rddata_en = 1'b0;
    tick(LAT + 1);
    check("mid_rq_empty_err", 128'(err), 128'(2));
    check("orphan_count", 128'(obs_q.size()), 128'(1));
    if (obs_q.size() > 0) begin
      check("orphan_cyc", 128'(obs_q[0].cyc), 128'(s + LAT));
      check("orphan_data", obs_q[0].data, '0);
    end
    do_reset();
    wr_beats(1, 128'h1, '0, 16'h0000);
    tick(1);
    check("mid_wq_empty_err", 128'(err), 128'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
